// File: rtl/photodiode_scan_pkg.sv
// photodiode_scan_pkg: shared state encoding and sizing helpers for the photodiode scan controller.
package photodiode_scan_pkg;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_FIRE, S_REPORT} scan_state_t;

    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // All-ones timestamp doubles as the "no edge seen" marker.
    function automatic int delay_max(input int tbits);
        return (1 << tbits) - 1;
    endfunction

endpackage

// File: rtl/photodiode_scan_ctrl_pd_edge_timestamp.sv
// pd_edge_timestamp: synchronizes one photodiode input and records the timestamp of its first
// rising edge inside the measurement window.
module pd_edge_timestamp
    import photodiode_scan_pkg::*;
#(
    parameter int TBITS = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pd,
    input  logic             clear,
    input  logic             window_active,
    input  logic [TBITS-1:0] t,
    output logic [TBITS-1:0] delay,
    output logic             hit
);
    localparam logic [TBITS-1:0] DELAY_MAX = TBITS'(delay_max(TBITS));

    logic [2:0]       sync_q;
    logic [TBITS-1:0] delay_q;
    logic             hit_q;
    logic             take;

    assign take = window_active && sync_q[1] && !sync_q[2] && !hit_q;

    always_ff @(posedge clk) begin
        sync_q <= rst ? 3'b000 : {sync_q[1:0], pd};
        if (rst || clear) begin
            delay_q <= DELAY_MAX;
            hit_q   <= 1'b0;
        end else if (take) begin
            delay_q <= t;
            hit_q   <= 1'b1;
        end
    end

    // Pass an edge captured this cycle straight through so the last window cycle is not lost.
    assign hit   = hit_q || take;
    assign delay = take ? t : delay_q;

endmodule

// File: rtl/photodiode_scan_ctrl.sv
// photodiode_scan_ctrl: fires emitters one at a time, timestamps first photodiode edges per slot,
// streams the per-slot delays and keeps a debounced per-emitter pressed bitmap.
module photodiode_scan_ctrl
    import photodiode_scan_pkg::*;
#(
    parameter int NPD    = 5,
    parameter int NEMIT  = 4,
    parameter int TBITS  = 12,
    parameter int SETTLE = 64,
    parameter int PULSE  = 2048,
    parameter int DEB    = 3,
    localparam int SW    = slot_w(NEMIT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NPD-1:0]       pd,
    input  logic [TBITS-1:0]     thresh,
    output logic [NEMIT-1:0]     emitter,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [SW-1:0]        m_slot,
    output logic [NPD*TBITS-1:0] m_delays,
    output logic [NPD-1:0]       m_hit,
    output logic [NEMIT-1:0]     pressed,
    output logic                 busy
);
    localparam int CW = (TBITS > $clog2(SETTLE + 1)) ? TBITS : $clog2(SETTLE + 1);
    localparam int DW = $clog2(DEB + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] T_LAST      = CW'((1 << TBITS) - 1);

    scan_state_t          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [SW-1:0]        slot_q, slot_d;
    logic [NPD*TBITS-1:0] delays;
    logic [NPD-1:0]       hits;
    logic [DW-1:0]        deb_q [NEMIT];
    logic                 fire_end;
    logic                 near;

    assign fire_end = state_q == S_FIRE && cnt_q == T_LAST;
    assign m_valid  = state_q == S_REPORT;
    assign busy     = state_q != S_IDLE;
    assign emitter  = (state_q == S_FIRE && int'(cnt_q) < PULSE) ? NEMIT'(1) << slot_q : '0;

    for (genvar i = 0; i < NPD; i++) begin : g_ch
        pd_edge_timestamp #(.TBITS(TBITS)) u_ch (
            .clk           (clk),
            .rst           (rst),
            .pd            (pd[i]),
            .clear         (state_q == S_SETTLE),
            .window_active (state_q == S_FIRE),
            .t             (cnt_q[TBITS-1:0]),
            .delay         (delays[i*TBITS +: TBITS]),
            .hit           (hits[i])
        );
    end

    always_comb begin
        near = 1'b0;
        for (int i = 0; i < NPD; i++)
            near = near | (hits[i] && delays[i*TBITS +: TBITS] < thresh);
    end

    // cnt counts settle cycles in SETTLE and is the timestamp t in FIRE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        case (state_q)
            S_IDLE: begin
                state_d = enable ? S_SETTLE : S_IDLE;
                cnt_d   = '0;
            end
            S_SETTLE: begin
                state_d = (cnt_q == SETTLE_LAST) ? S_FIRE : S_SETTLE;
                cnt_d   = (cnt_q == SETTLE_LAST) ? '0 : cnt_q + 1'b1;
            end
            S_FIRE: begin
                state_d = fire_end ? S_REPORT : S_FIRE;
                cnt_d   = fire_end ? '0 : cnt_q + 1'b1;
            end
            S_REPORT: if (m_ready) begin
                state_d = enable ? S_SETTLE : S_IDLE;
                cnt_d   = '0;
                slot_d  = (slot_q == SW'(NEMIT - 1)) ? '0 : slot_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_slot   <= '0;
            m_delays <= '0;
            m_hit    <= '0;
            pressed  <= '0;
            for (int i = 0; i < NEMIT; i++) deb_q[i] <= '0;
        end else if (fire_end) begin
            m_slot   <= slot_q;
            m_delays <= delays;
            m_hit    <= hits;
            if (near != pressed[slot_q]) begin
                if (deb_q[slot_q] == DW'(DEB - 1)) begin
                    pressed[slot_q] <= ~pressed[slot_q];
                    deb_q[slot_q]   <= '0;
                end else begin
                    deb_q[slot_q] <= deb_q[slot_q] + 1'b1;
                end
            end else begin
                deb_q[slot_q] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_photodiode_scan_ctrl.sv
// tb_photodiode_scan_ctrl: timeline-model bench for the photodiode scan controller, run with a
// shortened window so many debounce scans fit in a short simulation.
module tb_photodiode_scan_ctrl;
    localparam int NPD   = 5;
    localparam int NEMIT = 4;
    localparam int TBITS = 9;
    localparam int SET   = 16;
    localparam int W     = 1 << TBITS;
    localparam int PUL   = 256;
    localparam int DEB   = 3;
    localparam int NONE  = 100000;

    logic                 clk = 1'b0;
    logic                 rst, enable, m_ready;
    logic [NPD-1:0]       pd_v;
    logic [TBITS-1:0]     thresh;
    logic [NEMIT-1:0]     emitter, pressed;
    logic                 m_valid, busy;
    logic [1:0]           m_slot;
    logic [NPD*TBITS-1:0] m_delays;
    logic [NPD-1:0]       m_hit;

    photodiode_scan_ctrl #(
        .NPD(NPD), .NEMIT(NEMIT), .TBITS(TBITS), .SETTLE(SET), .PULSE(PUL), .DEB(DEB)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .pd(pd_v), .thresh(thresh),
        .emitter(emitter), .m_valid(m_valid), .m_ready(m_ready), .m_slot(m_slot),
        .m_delays(m_delays), .m_hit(m_hit), .pressed(pressed), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk = 0;

    logic [NEMIT-1:0]     exp_em, exp_pr;
    logic                 exp_valid, exp_busy;
    logic [1:0]           exp_slot;
    logic [NPD*TBITS-1:0] exp_delays;
    logic [NPD-1:0]       exp_hit;
    bit pr [NEMIT];
    int run [NEMIT];
    int slot_m;

    int k1 [NPD];
    int f1 [NPD];
    int k2 [NPD];
    bit pre [NPD];
    int stall_n, drop_c, rst_c;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) if (chk) begin
        check("emitter", 64'(emitter), 64'(exp_em));
        check("m_valid", 64'(m_valid), 64'(exp_valid));
        check("busy", 64'(busy), 64'(exp_busy));
        check("m_slot", 64'(m_slot), 64'(exp_slot));
        check("m_delays", 64'(m_delays), 64'(exp_delays));
        check("m_hit", 64'(m_hit), 64'(exp_hit));
        check("pressed", 64'(pressed), 64'(exp_pr));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < NPD; i++) begin
            k1[i] = NONE; f1[i] = NONE; k2[i] = NONE; pre[i] = 1'b0;
        end
        stall_n = 0; drop_c = -1; rst_c = -1;
    endtask

    task automatic reset_model();
        exp_em = '0; exp_valid = 1'b0; exp_busy = 1'b0; exp_slot = '0;
        exp_delays = '0; exp_hit = '0; exp_pr = '0; slot_m = 0;
        for (int i = 0; i < NEMIT; i++) begin pr[i] = 1'b0; run[i] = 0; end
    endtask

    task automatic load_report(input int sl);
        bit near = 1'b0;
        exp_slot = 2'(sl);
        for (int i = 0; i < NPD; i++) begin
            bit h = !pre[i] && (k1[i] + 2 <= W - 1);
            int d = h ? k1[i] + 2 : W - 1;
            exp_delays[i*TBITS +: TBITS] = TBITS'(d);
            exp_hit[i] = h;
            if (h && d < int'(thresh)) near = 1'b1;
        end
        if (near != pr[sl]) begin
            run[sl]++;
            if (run[sl] == DEB) begin pr[sl] = !pr[sl]; run[sl] = 0; end
        end else run[sl] = 0;
        for (int i = 0; i < NEMIT; i++) exp_pr[i] = pr[i];
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            step();
            exp_busy = 1'b0; exp_em = '0; exp_valid = 1'b0;
            m_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // One scan slot on an absolute timeline: SETTLE cycles, then the W-cycle window, then REPORT.
    task automatic run_slot();
        int sl = slot_m;
        for (int c = 0; ; c++) begin
            step();
            exp_busy = 1'b1;
            if (c < SET) begin
                exp_em = '0; exp_valid = 1'b0; m_ready = 1'b1;
                for (int i = 0; i < NPD; i++) pd_v[i] = pre[i];
            end else if (c < SET + W) begin
                int t = c - SET;
                exp_em = (t < PUL) ? NEMIT'(1) << sl : '0;
                exp_valid = 1'b0; m_ready = 1'b1;
                for (int i = 0; i < NPD; i++)
                    pd_v[i] = pre[i] || (t >= k1[i] && t < f1[i]) || t >= k2[i];
            end else begin
                if (c == SET + W) load_report(sl);
                exp_em = '0; exp_valid = 1'b1; pd_v = '0;
                m_ready = (c - SET - W) >= stall_n;
            end
            if (c == drop_c) enable = 1'b0;
            if (c == rst_c) begin
                rst = 1'b1;
                step();
                reset_model();
                rst = 1'b0; enable = 1'b0; pd_v = '0;
                return;
            end
            if (c >= SET + W && m_ready) break;
        end
        slot_m = (slot_m + 1) % NEMIT;
    endtask

    int near_pat [11] = '{1, 1, 1, 0, 0, 0, 1, 0, 1, 1, 1};

    initial begin
        rst = 1'b1; enable = 1'b0; pd_v = '0; m_ready = 1'b1; thresh = '0;
        clear_cfg();
        step(); step();
        reset_model();
        chk = 1'b1;
        rst = 1'b0;
        idle_cycles(4);
        enable = 1'b1;

        clear_cfg(); k1[0] = 100;
        run_slot();
        check("lit_slot0", 64'(m_slot), 64'd0);
        check("lit_delay0", 64'(m_delays[8:0]), 64'd102);
        check("lit_delay1_none", 64'(m_delays[17:9]), 64'd511);
        check("lit_hit_slot0", 64'(m_hit), 64'b00001);

        clear_cfg();
        k1[2] = 10; f1[2] = 20; k2[2] = 500;
        k1[3] = 510; k1[4] = 509; pre[1] = 1'b1;
        run_slot();
        check("lit_delay2_first", 64'(m_delays[26:18]), 64'd12);
        check("lit_delay3_late", 64'(m_delays[35:27]), 64'd511);
        check("lit_delay4_last", 64'(m_delays[44:36]), 64'd511);
        check("lit_hit_slot1", 64'(m_hit), 64'b10100);

        thresh = 9'd200;
        for (int n = 0; n < 42; n++) begin
            clear_cfg();
            if (slot_m == 2) begin
                k1[1] = near_pat[n / 4] ? 48 : 198;
                stall_n = (n == 0) ? 50 : 0;
            end else if (slot_m == 3) k1[3] = 300;
            run_slot();
            if (slot_m == 3) begin
                if (n / 4 == 2)  check("lit_pressed_set", 64'(pressed), 64'b0100);
                if (n / 4 == 5)  check("lit_pressed_clr", 64'(pressed), 64'b0000);
                if (n / 4 == 9)  check("lit_pressed_hold", 64'(pressed), 64'b0000);
                if (n / 4 == 10) check("lit_pressed_reset", 64'(pressed), 64'b0100);
            end
        end

        clear_cfg();
        run_slot();
        clear_cfg(); k1[0] = 40; drop_c = SET + 200;
        run_slot();
        check("lit_drop_slot", 64'(m_slot), 64'd1);
        idle_cycles(10);
        check("lit_idle_busy", 64'(busy), 64'd0);
        check("lit_idle_emitter", 64'(emitter), 64'd0);

        enable = 1'b1;
        clear_cfg(); k1[1] = 20; rst_c = SET + 300;
        run_slot();
        check("lit_rst_pressed", 64'(pressed), 64'd0);
        check("lit_rst_valid", 64'(m_valid), 64'd0);
        check("lit_rst_delays", 64'(m_delays), 64'd0);
        idle_cycles(5);

        enable = 1'b1;
        clear_cfg(); k1[0] = 5;
        run_slot();
        check("lit_restart_delay", 64'(m_delays[8:0]), 64'd7);
        check("lit_restart_hit", 64'(m_hit), 64'b00001);
        enable = 1'b0;
        idle_cycles(3);

        chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/photodiode_scan_ctrl.md
Name: photodiode_scan_ctrl

Overview:
- Time-multiplexed optical-button scan controller: fires NEMIT emitters one at a time and timestamps the first rising edge on each of NPD photodiode inputs relative to emitter fire.
- Per slot, reports per-channel delays on a valid/ready stream, then updates a debounced per-emitter "pressed" bitmap.
- Sits between the emitter drivers / photodiode comparators and the PS-side register/stream logic.

Parameters:
NPD, 5, number of photodiode channels
NEMIT, 4, number of emitters scanned (≥2)
TBITS, 12, delay timestamp width; measurement window = 2^TBITS cycles
SETTLE, 64, idle cycles with all emitters off before each fire
PULSE, 2048, cycles the emitter is driven at the start of the window (PULSE ≤ 2^TBITS)
DEB, 3, consecutive scans required to set or clear a pressed bit

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
enable  in  1  run scanning
pd  in  NPD  asynchronous photodiode comparator outputs
thresh  in  TBITS  delay strictly below thresh counts as "near"
emitter  out  NEMIT  one-hot emitter drive, all-zero when not firing
m_valid  out  1  slot result valid
m_ready  in  1  consumer accepts result
m_slot  out  clog2(NEMIT)  emitter index of result
m_delays  out  NPD*TBITS  channel i at [i*TBITS +: TBITS]
m_hit  out  NPD  edge seen in window, per channel
pressed  out  NEMIT  debounced press state
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: state IDLE, slot 0, emitter=0, m_valid=0, m_slot=0, m_delays=0, m_hit=0, pressed=0, busy=0, debounce counters=0, sync flops=0. Reset mid-operation clears emitter on the next edge. The in-flight result is discarded.
- States: IDLE → SETTLE (enable=1) → FIRE → REPORT → SETTLE (enable=1) or IDLE (enable=0).
- SETTLE: emitter=0 for exactly SETTLE cycles.
- FIRE: timestamp counter t runs 0..2^TBITS-1, one cycle each. emitter[slot]=1 while t<PULSE. Leave FIRE after t=2^TBITS-1.
- Capture: pd passes through a 2-FF synchronizer, then rising-edge detection on the synced value. Edge detection is also active in SETTLE so a channel already high at t=0 produces no hit.
  - pd first sampled high at the clock edge ending FIRE cycle k → delay = k+2 and hit=1, if k+2 ≤ 2^TBITS-1.
  - Only the first edge per channel per slot is recorded.
  - No edge: delay = all-ones, hit=0.
  - Edges in SETTLE, REPORT or IDLE are ignored.
- REPORT entry: m_valid=1, and m_slot/m_delays/m_hit are loaded. Outputs are held stable while m_valid && !m_ready. The scan stalls under backpressure with emitter=0.
- Handshake: transfer on m_valid && m_ready. m_valid drops the next cycle. Slot increments and wraps NEMIT-1 → 0.
- Debounce, evaluated once on REPORT entry with thresh sampled that cycle:
  - near = OR over channels of (hit && delay < thresh).
  - If near ≠ pressed[slot], increment that slot's counter; otherwise clear it.
  - When the counter reaches DEB, toggle pressed[slot] and clear the counter.
- enable deassert: the current slot completes through the REPORT handshake, then the block goes to IDLE. Slot index is kept. Re-enable restarts at SETTLE.
- thresh=0: nothing is ever near. Delays saturate; there is no wrap.

Decomposition:
- Package photodiode_scan_pkg: state enum (IDLE, SETTLE, FIRE, REPORT), slot-width function, DELAY_MAX constant.
- Sub-module pd_edge_timestamp: per-channel synchronizer, edge detect, first-edge capture. Inputs: clk, rst, clear, window_active, t. Outputs: delay, hit. Instantiated NPD times.

Test Plan:
- pd[0] rises at FIRE t=100 for slot 0, others low → m_slot=0, delay0=102, hit=5'b00001, others 4095/hit 0.
- pd[2] pulses twice (t=10, t=500) → delay2=12, only the first edge kept.
- m_ready held low 50 cycles at REPORT → m_valid and data stable, emitter=0 throughout; slot advances to 1 only after the handshake.
- thresh=200, pd[1] edge t=50 on slot 2 for 3 consecutive scans → pressed[2] sets after the third REPORT. Then 3 scans with no edge → it clears. A near/far/near/near/near pattern sets only on the fifth scan.
- enable dropped mid-FIRE of slot 1 → slot 1 reported normally, then IDLE with busy=0 and emitter=0.
- rst asserted at FIRE t=1000 → next cycle all outputs at reset values; pressed=0; no m_valid for that slot.
